// File: rtl/spi_minion_adapter_mc.sv
// Multi-channel SPI minion adapter: routes SPI write frames into per-channel
// outbound queues and serves SPI read frames round-robin from per-channel
// inbound queues, tagging each popped entry with its source channel.
module spi_minion_adapter_mc #(
  parameter int unsigned pw          = 6,
  parameter int unsigned nchan       = 4,
  parameter int unsigned num_entries = 2,
  localparam int unsigned ca = (nchan > 1) ? $clog2(nchan) : 1,
  localparam int unsigned fw = ca + pw
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic                  push_msg_val_wrt,
  input  logic                  push_msg_val_rd,
  input  logic [fw-1:0]         push_msg_data,
  input  logic                  pull_en,
  output logic                  pull_msg_val,
  output logic                  pull_msg_spc,
  output logic [fw-1:0]         pull_msg_data,
  input  logic [nchan*pw-1:0]   recv_msg,
  input  logic [nchan-1:0]      recv_val,
  output logic [nchan-1:0]      recv_rdy,
  output logic [nchan*pw-1:0]   send_msg,
  output logic [nchan-1:0]      send_val,
  input  logic [nchan-1:0]      send_rdy,
  output logic [nchan-1:0]      parity,
  output logic [nchan-1:0]      ovf,
  output logic                  bad_addr
);

  localparam int unsigned ptr_w = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int unsigned cnt_w = $clog2(num_entries) + 1;

  logic             wr;
  logic             rd;
  logic             chan_ok;
  logic             found;
  logic             pop;
  logic [ca-1:0]    chan;
  logic [ca-1:0]    grant;
  logic [ca-1:0]    scan_idx;
  logic [ca-1:0]    rr;
  logic [pw-1:0]    payload;
  logic [nchan-1:0] mc_full;
  logic [nchan-1:0] mc_empty;
  logic [nchan-1:0] mc_hit;
  logic [nchan-1:0] cm_full;
  logic [nchan-1:0] cm_empty;
  logic [nchan-1:0] spc_ok;
  logic [pw-1:0]    cm_head [nchan];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(num_entries - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr      = push_en & push_msg_val_wrt;
  assign rd      = push_en & push_msg_val_rd & pull_en;
  assign chan    = push_msg_data[fw-1:pw];
  assign payload = push_msg_data[pw-1:0];
  assign chan_ok = (32'(chan) < nchan);

  for (genvar i = 0; i < nchan; i++) begin : g_chan
    logic [pw-1:0]    mc_mem [num_entries];
    logic [pw-1:0]    cm_mem [num_entries];
    logic [ptr_w-1:0] mc_wp, mc_rp, cm_wp, cm_rp;
    logic [cnt_w-1:0] mc_cnt, cm_cnt;
    logic             mc_enq, mc_deq, cm_enq, cm_deq;
    logic             ovf_q;

    assign mc_full[i]  = (mc_cnt == cnt_w'(num_entries));
    assign mc_empty[i] = (mc_cnt == '0);
    assign cm_full[i]  = (cm_cnt == cnt_w'(num_entries));
    assign cm_empty[i] = (cm_cnt == '0);

    assign mc_hit[i] = wr & chan_ok & (chan == ca'(i));
    assign mc_enq    = mc_hit[i] & ~mc_full[i];
    assign mc_deq    = ~mc_empty[i] & send_rdy[i];
    assign cm_enq    = recv_val[i] & ~cm_full[i];
    assign cm_deq    = pop & (grant == ca'(i));

    // A hit on channel i consumes one slot, so space must remain beyond it.
    assign spc_ok[i] = mc_hit[i] ? (mc_cnt < cnt_w'(num_entries - 1)) : ~mc_full[i];

    assign send_val[i]            = ~mc_empty[i];
    assign send_msg[i*pw +: pw]   = mc_empty[i] ? '0 : mc_mem[mc_rp];
    assign recv_rdy[i]            = ~cm_full[i];
    assign cm_head[i]             = cm_mem[cm_rp];
    assign parity[i]              = (^send_msg[i*pw +: pw]) & send_val[i];
    assign ovf[i]                 = ovf_q;

    // Outbound queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mc_wp  <= '0;
        mc_rp  <= '0;
        mc_cnt <= '0;
      end else begin
        if (mc_enq) mc_wp <= ptr_inc(mc_wp);
        if (mc_deq) mc_rp <= ptr_inc(mc_rp);
        unique case ({mc_enq, mc_deq})
          2'b10:   mc_cnt <= mc_cnt + 1'b1;
          2'b01:   mc_cnt <= mc_cnt - 1'b1;
          default: ;
        endcase
      end
    end

    // Inbound queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cm_wp  <= '0;
        cm_rp  <= '0;
        cm_cnt <= '0;
      end else begin
        if (cm_enq) cm_wp <= ptr_inc(cm_wp);
        if (cm_deq) cm_rp <= ptr_inc(cm_rp);
        unique case ({cm_enq, cm_deq})
          2'b10:   cm_cnt <= cm_cnt + 1'b1;
          2'b01:   cm_cnt <= cm_cnt - 1'b1;
          default: ;
        endcase
      end
    end

    // Queue storage; contents are only observable through non-empty heads.
    always_ff @(posedge clk) begin
      if (mc_enq) mc_mem[mc_wp] <= payload;
      if (cm_enq) cm_mem[cm_wp] <= recv_msg[i*pw +: pw];
    end

    // Sticky overflow: a write arrived while this channel's queue was full.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     ovf_q <= 1'b0;
      else if (mc_hit[i] & mc_full[i]) ovf_q <= 1'b1;
    end
  end

  // Round-robin scan from rr; walking backwards lets the nearest hit win.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int unsigned k = nchan; k > 0; k--) begin
      scan_idx = ca'((32'(rr) + k - 1) % nchan);
      if (!cm_empty[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  assign pop           = rd & found;
  assign pull_msg_val  = pop;
  assign pull_msg_data = pop ? {grant, cm_head[grant]} : '0;
  assign pull_msg_spc  = &spc_ok;

  // Round-robin pointer advances past the granted channel on each pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rr <= '0;
    else if (pop) rr <= ca'((32'(grant) + 1) % nchan);
  end

  // Sticky bad-address flag for writes to non-existent channels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              bad_addr <= 1'b0;
    else if (wr && !chan_ok) bad_addr <= 1'b1;
  end

endmodule

// File: tb/tb_spi_minion_adapter_mc.sv
// Bench for spi_minion_adapter_mc: a 4-channel instance driven from a vector
// table with queue scoreboards, and a 3-channel instance for address corners.
module tb_spi_minion_adapter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 4-channel, depth-2 instance
  logic        a_push_en, a_wrt, a_rd, a_pull_en;
  logic [7:0]  a_data, a_pd;
  logic        a_pv, a_spc, a_bad;
  logic [23:0] a_recv_msg, a_send_msg;
  logic [3:0]  a_recv_val, a_recv_rdy, a_send_val, a_send_rdy, a_parity, a_ovf;

  // 3-channel, depth-2 instance
  logic        b_push_en, b_wrt, b_rd, b_pull_en;
  logic [7:0]  b_data, b_pd;
  logic        b_pv, b_spc, b_bad;
  logic [17:0] b_recv_msg, b_send_msg;
  logic [2:0]  b_recv_val, b_recv_rdy, b_send_val, b_send_rdy, b_parity, b_ovf;

  spi_minion_adapter_mc #(.pw(6), .nchan(4), .num_entries(2)) u_a (
    .clk(clk), .reset(rst_n), .push_en(a_push_en), .push_msg_val_wrt(a_wrt),
    .push_msg_val_rd(a_rd), .push_msg_data(a_data), .pull_en(a_pull_en),
    .pull_msg_val(a_pv), .pull_msg_spc(a_spc), .pull_msg_data(a_pd),
    .recv_msg(a_recv_msg), .recv_val(a_recv_val), .recv_rdy(a_recv_rdy),
    .send_msg(a_send_msg), .send_val(a_send_val), .send_rdy(a_send_rdy),
    .parity(a_parity), .ovf(a_ovf), .bad_addr(a_bad)
  );

  spi_minion_adapter_mc #(.pw(6), .nchan(3), .num_entries(2)) u_b (
    .clk(clk), .reset(rst_n), .push_en(b_push_en), .push_msg_val_wrt(b_wrt),
    .push_msg_val_rd(b_rd), .push_msg_data(b_data), .pull_en(b_pull_en),
    .pull_msg_val(b_pv), .pull_msg_spc(b_spc), .pull_msg_data(b_pd),
    .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(b_send_rdy),
    .parity(b_parity), .ovf(b_ovf), .bad_addr(b_bad)
  );

  int total = 0;
  int nbad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboards: expected queue contents per channel
  logic [5:0] sb_mc [4][$];
  logic [5:0] sb_cm [4][$];
  logic [3:0] m_ovf;

  typedef struct {
    bit          wr;
    int unsigned wch;
    logic [5:0]  wpl;
    bit          rd;
    logic [3:0]  rv;
    logic [23:0] rmsg;
    logic [3:0]  srdy;
    bit          pv;    // expected pull_msg_val
    int unsigned pch;   // expected source channel when pv
    bit          spc;   // expected pull_msg_spc
  } vec_t;

  function automatic vec_t mk(bit wr, int unsigned wch, logic [5:0] wpl, bit rd,
                              logic [3:0] rv, logic [23:0] rmsg, logic [3:0] srdy,
                              bit pv, int unsigned pch, bit spc);
    vec_t v;
    v.wr = wr; v.wch = wch; v.wpl = wpl; v.rd = rd; v.rv = rv; v.rmsg = rmsg;
    v.srdy = srdy; v.pv = pv; v.pch = pch; v.spc = spc;
    return v;
  endfunction

  task automatic idle_a();
    a_push_en = 0; a_wrt = 0; a_rd = 0; a_pull_en = 0; a_data = '0;
    a_recv_val = '0; a_recv_msg = '0;
  endtask

  task automatic idle_b();
    b_push_en = 0; b_wrt = 0; b_rd = 0; b_pull_en = 0; b_data = '0;
    b_recv_val = '0; b_recv_msg = '0;
  endtask

  // One frame on instance A: drive, check pull path, clock, check queue side.
  task automatic step_a(input vec_t v, input int idx);
    logic [3:0] deq, acc;
    logic [7:0] exp_d;
    logic [5:0] h;
    a_send_rdy = v.srdy;
    for (int i = 0; i < 4; i++) begin
      deq[i] = (sb_mc[i].size() > 0) && v.srdy[i];
      acc[i] = v.rv[i] && (sb_cm[i].size() < 2);
    end
    a_push_en = v.wr | v.rd; a_wrt = v.wr; a_rd = v.rd; a_pull_en = v.rd;
    a_data = {v.wch[1:0], v.wpl};
    a_recv_val = v.rv; a_recv_msg = v.rmsg;
    exp_d = '0;
    if (v.pv) begin
      h = (sb_cm[v.pch].size() > 0) ? sb_cm[v.pch].pop_front() : 6'h00;
      exp_d = {v.pch[1:0], h};
    end
    if (v.wr) begin
      if (sb_mc[v.wch].size() < 2) sb_mc[v.wch].push_back(v.wpl);
      else m_ovf[v.wch] = 1'b1;
    end
    for (int i = 0; i < 4; i++)
      if (acc[i]) sb_cm[i].push_back(v.rmsg[i*6 +: 6]);
    #3;
    chk($sformatf("v%0d pull_val", idx), a_pv, v.pv);
    chk($sformatf("v%0d pull_data", idx), a_pd, exp_d);
    chk($sformatf("v%0d spc", idx), a_spc, v.spc);
    @(posedge clk); #1;
    idle_a();
    for (int i = 0; i < 4; i++)
      if (deq[i]) void'(sb_mc[i].pop_front());
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d send_val%0d", idx, i), a_send_val[i], sb_mc[i].size() > 0);
      if (sb_mc[i].size() > 0) begin
        chk($sformatf("v%0d send_msg%0d", idx, i), a_send_msg[i*6 +: 6], sb_mc[i][0]);
        chk($sformatf("v%0d parity%0d", idx, i), a_parity[i], ^sb_mc[i][0]);
      end else begin
        chk($sformatf("v%0d parity%0d", idx, i), a_parity[i], 1'b0);
      end
      chk($sformatf("v%0d recv_rdy%0d", idx, i), a_recv_rdy[i], sb_cm[i].size() < 2);
    end
    chk($sformatf("v%0d ovf", idx), a_ovf, m_ovf);
    chk($sformatf("v%0d bad_addr", idx), a_bad, 1'b0);
  endtask

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // routing, then overflow on channel 1, then round-robin reads
    tbl[0]  = mk(1, 2, 6'h15, 0, 4'h0, 24'h0, 4'h0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 6'h2A, 0, 4'h0, 24'h0, 4'h0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 6'h11, 0, 4'h0, 24'h0, 4'h0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 6'h22, 0, 4'h0, 24'h0, 4'h0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 6'h33, 0, 4'h0, 24'h0, 4'h0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 6'h00, 0, 4'b1011, {6'h04, 6'h00, 6'h02, 6'h01}, 4'h0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 3, 0);
    tbl[9]  = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 0, 0, 0);
    // drain outbound queues
    tbl[10] = mk(0, 0, 6'h00, 0, 4'h0, 24'h0, 4'hF, 0, 0, 0);
    tbl[11] = mk(0, 0, 6'h00, 0, 4'h0, 24'h0, 4'hF, 0, 0, 1);
    // concurrent write+read, rr wrap, recv/read in same frame (no bypass)
    tbl[12] = mk(0, 0, 6'h00, 0, 4'b1100, {6'h3D, 6'h2C, 6'h00, 6'h00}, 4'h0, 0, 0, 1);
    tbl[13] = mk(1, 0, 6'h0F, 1, 4'h0, 24'h0, 4'h0, 1, 2, 1);
    tbl[14] = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 3, 1);
    tbl[15] = mk(0, 0, 6'h00, 1, 4'b0001, {18'h0, 6'h3F}, 4'h0, 0, 0, 1);
    tbl[16] = mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 0, 1);
    tbl[17] = mk(1, 3, 6'h3F, 0, 4'h0, 24'h0, 4'hF, 0, 0, 1);
    tbl[18] = mk(0, 0, 6'h00, 0, 4'h0, 24'h0, 4'hF, 0, 0, 1);

    m_ovf = '0;
    rst_n = 1'b0;
    idle_a(); idle_b();
    a_send_rdy = '0; b_send_rdy = '0;
    #2;
    chk("rst a send_val", a_send_val, 4'h0);
    chk("rst a recv_rdy", a_recv_rdy, 4'hF);
    chk("rst a pull_val", a_pv, 1'b0);
    chk("rst a pull_data", a_pd, 8'h00);
    chk("rst a spc", a_spc, 1'b1);
    chk("rst a parity", a_parity, 4'h0);
    chk("rst a ovf", a_ovf, 4'h0);
    chk("rst a bad_addr", a_bad, 1'b0);
    chk("rst b send_val", b_send_val, 3'h0);
    chk("rst b recv_rdy", b_recv_rdy, 3'h7);
    chk("rst b bad_addr", b_bad, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) step_a(tbl[i], i);

    // Mid-operation reset: leave rr=2, data in mc2 and cm0, ovf[1] set
    step_a(mk(0, 0, 6'h00, 0, 4'b0011, {12'h0, 6'h06, 6'h05}, 4'h0, 0, 0, 1), 100);
    step_a(mk(1, 2, 6'h2B, 1, 4'h0, 24'h0, 4'h0, 1, 1, 1), 101);
    #2;
    rst_n = 1'b0;
    a_push_en = 1; a_rd = 1; a_pull_en = 1;
    #1;
    chk("midrst send_val", a_send_val, 4'h0);
    chk("midrst recv_rdy", a_recv_rdy, 4'hF);
    chk("midrst ovf", a_ovf, 4'h0);
    chk("midrst pull_val", a_pv, 1'b0);
    chk("midrst pull_data", a_pd, 8'h00);
    chk("midrst spc", a_spc, 1'b1);
    idle_a();
    for (int i = 0; i < 4; i++) begin
      sb_mc[i].delete();
      sb_cm[i].delete();
    end
    m_ovf = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // rr must restart at 0: channel 1 wins over channel 2
    step_a(mk(0, 0, 6'h00, 0, 4'b0110, {6'h00, 6'h09, 6'h08, 6'h00}, 4'h0, 0, 0, 1), 102);
    step_a(mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 1, 1), 103);
    step_a(mk(0, 0, 6'h00, 1, 4'h0, 24'h0, 4'h0, 1, 2, 1), 104);

    // Instance B: bad address on a 3-channel build
    b_push_en = 1; b_wrt = 1; b_data = {2'd3, 6'h12};
    #3;
    chk("b badwr spc", b_spc, 1'b1);
    @(posedge clk); #1;
    idle_b();
    chk("b bad_addr", b_bad, 1'b1);
    chk("b badwr send_val", b_send_val, 3'h0);
    chk("b badwr ovf", b_ovf, 3'h0);
    // load cm2
    b_recv_val = 3'b100; b_recv_msg = {6'h19, 12'h0};
    @(posedge clk); #1;
    idle_b();
    // concurrent write ch0 + read: grant ch2, rr wraps to 0
    b_push_en = 1; b_wrt = 1; b_rd = 1; b_pull_en = 1; b_data = {2'd0, 6'h0A};
    #3;
    chk("b conc pull_val", b_pv, 1'b1);
    chk("b conc pull_data", b_pd, {2'd2, 6'h19});
    @(posedge clk); #1;
    idle_b();
    chk("b conc send_val", b_send_val, 3'b001);
    chk("b conc send_msg", b_send_msg[5:0], 6'h0A);
    chk("b conc parity", b_parity, 3'b000);
    b_recv_val = 3'b101; b_recv_msg = {6'h22, 6'h00, 6'h21};
    @(posedge clk); #1;
    idle_b();
    b_push_en = 1; b_rd = 1; b_pull_en = 1;
    #3;
    chk("b rr0 pull_data", b_pd, {2'd0, 6'h21});
    @(posedge clk); #1;
    #3;
    chk("b rr1 pull_data", b_pd, {2'd2, 6'h22});
    @(posedge clk); #1;
    #3;
    chk("b empty pull_val", b_pv, 1'b0);
    chk("b empty pull_data", b_pd, 8'h00);
    @(posedge clk); #1;
    idle_b();

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule

// File: doc/spi_minion_adapter_mc.md
# spi_minion_adapter_mc

Multi-channel, parametrised successor to the single-channel SPI minion adapter. Sits between the SPI minion frame engine (push/pull frame interface) and `nchan` independent valid/ready streams in the design. Each SPI write frame carries a channel address and is routed into that channel's outbound queue. Each SPI read frame pops one entry, chosen round-robin among non-empty inbound queues, and tags it with its source channel. Adds per-channel queue depth, sticky overflow/bad-address flags and per-channel parity.

## Interface
- `pw`, 6: payload width per channel message
- `nchan`, 4: number of channels; 1..16
- `num_entries`, 2: depth of each per-channel queue (≥1)
- `ca` (derived), max(1, $clog2(nchan)): channel-address width; frame width `fw = ca + pw`

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `push_en`  in  1  frame strobe from minion engine
- `push_msg_val_wrt`  in  1  frame is a write
- `push_msg_val_rd`  in  1  frame requests a read
- `push_msg_data`  in  fw  {chan[ca-1:0], payload[pw-1:0]}
- `pull_en`  in  1  engine is sampling pull data this cycle
- `pull_msg_val`  out  1  pull_msg_data holds a popped entry
- `pull_msg_spc`  out  1  every outbound queue can accept another frame
- `pull_msg_data`  out  fw  {src chan, payload}; zero when not valid
- `recv_msg`  in  nchan*pw  inbound messages, channel i at [i*pw +: pw]
- `recv_val` / `recv_rdy`  in / out  nchan  inbound handshakes
- `send_msg`  out  nchan*pw  outbound messages
- `send_val` / `send_rdy`  out / in  nchan  outbound handshakes
- `parity`  out  nchan  parity[i] = ^send_msg[i] & send_val[i]
- `ovf`  out  nchan  sticky: write dropped on full queue i
- `bad_addr`  out  1  sticky: write to chan ≥ nchan

## Operation
- Per channel: one outbound queue (mc) and one inbound queue (cm), each a normal (non-pipe, non-bypass) FIFO of `num_entries`; recv_rdy[i] = ~full(cm[i]); send_val[i] = ~empty(mc[i]).
- Write: wr = push_en & push_msg_val_wrt. chan < nchan and mc[chan] not full → enqueue payload. chan full → drop, set ovf[chan]. chan ≥ nchan → drop, set bad_addr. No queue touched on drop.
- spc: pull_msg_spc = AND over i of (free_i − (wr & chan==i) ≥ 1); i.e. space remains after this cycle's write in every channel.
- Read: rd = push_en & push_msg_val_rd & pull_en. Grant g = first non-empty cm[j] scanning j = rr, rr+1, … mod nchan. If rd and any non-empty: pop cm[g], pull_msg_val=1, pull_msg_data={g, head}; rr ← (g+1) mod nchan. If rd and all empty: pull_msg_val=0, data 0, rr unchanged.
- Pull path combinational from registered queue heads and rr; rr updates only on an actual pop.
- Simultaneous write and read in one frame both execute (different queues).
- Reset (async, low): all queues empty, rr=0, ovf=0, bad_addr=0; outputs: send_val=0, recv_rdy=all 1, pull_msg_val=0, pull_msg_data=0, pull_msg_spc=1 (when num_entries≥2; equals ~wr-dependent when num_entries=1), parity=0. Reset mid-operation discards all queued data.
- Sticky flags clear only on reset.

## Timing
- Write at edge t → send_val[chan]=1 in cycle t+1 (1-cycle latency); inbound recv handshake at t → eligible for pull in t+1.
- Full queue: enq and deq in same cycle on full queue not permitted (recv_rdy low while full); on empty queue, no bypass.
- Queue pointers wrap mod num_entries; counts width $clog2(num_entries)+1.
- num_entries=1: pull_msg_spc=0 in any cycle with a valid write.

## Test plan
- Reset: hold reset=0 mid-stream with data in all queues → all send_val=0, recv_rdy=all 1, ovf=0, rr=0, pull_msg_val=0 within same cycle.
- Routing: nchan=4, write frames {2,0x15},{0,0x2A} → cycle after each, send_val[2] with 0x15 (parity 1), send_val[0] with 0x2A (parity 1).
- Round-robin: cm[0],cm[1],cm[3] each hold one entry, rr=0 → three reads return chan 0,1,3 in order; fourth read pull_msg_val=0, data 0.
- Overflow: num_entries=2, send_rdy[1]=0, three writes to chan 1 → pull_msg_spc=0 during second write, third dropped, ovf[1]=1, queue holds first two.
- Bad address: nchan=3, write chan 3 → bad_addr=1, no send_val change.
- Concurrent: write chan 0 and read in same frame with cm[2] non-empty → mc[0] enqueued, pull returns {2,head}, rr=3 mod 3=0.
